// File: rtl/generador_trigger_ultrasonido.sv
// Trigger/echo sequencer for an HC-SR04-style ranger: pulses trig, times the echo
// high width in clock cycles and enforces the minimum trigger repetition period.
module generador_trigger_ultrasonido #(
  parameter int unsigned TRIG_CYCLES         = 500,
  parameter int unsigned PERIOD_CYCLES       = 3000000,
  parameter int unsigned ECHO_TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        midiendo,
  output logic [19:0] echo_cycles,
  output logic        dato_valido,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam logic [19:0] TRIG_LAST    = 20'(TRIG_CYCLES - 1);
  localparam logic [21:0] PERIOD_LAST  = 22'(PERIOD_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(ECHO_TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic        echo_meta_reg;
  logic        echo_s_reg;
  logic        echo_prev_reg;
  logic [19:0] t_reg;
  logic [21:0] periodo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      echo_meta_reg <= 1'b0;
      echo_s_reg    <= 1'b0;
      echo_prev_reg <= 1'b0;
      t_reg         <= '0;
      periodo_reg   <= '0;
      trig          <= 1'b0;
      midiendo      <= 1'b0;
      echo_cycles   <= '0;
      dato_valido   <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      echo_meta_reg <= echo;
      echo_s_reg    <= echo_meta_reg;
      echo_prev_reg <= echo_s_reg;
      dato_valido   <= 1'b0;
      timeout       <= 1'b0;
      t_reg         <= t_reg + 20'd1;
      // periodo saturates so HOLDOFF can wait indefinitely on a stuck echo
      if (periodo_reg != PERIOD_LAST) begin
        periodo_reg <= periodo_reg + 22'd1;
      end

      case (state_reg)
        IDLE: begin
          t_reg <= '0;
          if (enable || start) begin
            state_reg   <= TRIGGER;
            trig        <= 1'b1;
            midiendo    <= 1'b1;
            periodo_reg <= '0;
          end
        end

        TRIGGER: begin
          if (t_reg == TRIG_LAST) begin
            state_reg <= WAIT_RISE;
            trig      <= 1'b0;
            t_reg     <= '0;
          end
        end

        WAIT_RISE: begin
          // a level already high on entry is not an edge: echo_prev must be 0
          if (echo_s_reg && !echo_prev_reg) begin
            state_reg <= MEASURE;
            t_reg     <= 20'd1;
          end else if (t_reg == TIMEOUT_LAST) begin
            state_reg <= HOLDOFF;
            timeout   <= 1'b1;
            t_reg     <= '0;
          end
        end

        MEASURE: begin
          if (!echo_s_reg) begin
            state_reg   <= HOLDOFF;
            echo_cycles <= t_reg;
            dato_valido <= 1'b1;
            t_reg       <= '0;
          end else if (t_reg == TIMEOUT_LAST) begin
            state_reg <= HOLDOFF;
            timeout   <= 1'b1;
            t_reg     <= '0;
          end
        end

        HOLDOFF: begin
          if (periodo_reg == PERIOD_LAST && !echo_s_reg) begin
            t_reg <= '0;
            if (enable) begin
              state_reg   <= TRIGGER;
              trig        <= 1'b1;
              periodo_reg <= '0;
            end else begin
              state_reg <= IDLE;
              midiendo  <= 1'b0;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          trig      <= 1'b0;
          midiendo  <= 1'b0;
          t_reg     <= '0;
        end
      endcase
    end
  end

endmodule
